// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [15:0] INST_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALTED  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [DW-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH entries, wrapping pointers, synchronous clear that beats push/pop.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop & !empty & !clear;
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
  assign push_ok_s = push & !clear & (!full_s | pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through counted, valid slots.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, prefetch FIFO and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            QDEPTH   = 2,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          en_pc,
  input  logic          en_ifid,
  input  logic          flush_ifid,
  input  logic          halt,
  fetch_unit_if.master  imem,
  output logic [DW-1:0] inst_id,
  output logic [AW-1:0] pcinc_id,
  output logic          flushed
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t   state_r;
  fetch_state_t   state_s;
  logic [AW-1:0]  pc_r;
  logic [AW-1:0]  req_pc_r;
  logic           outstanding_r;
  logic           started_r;
  logic           jump_s;
  logic           issue_s;
  logic           push_s;
  logic           pop_s;
  logic           resp_s;
  logic [DW+AW-1:0] fifo_wdata_s;
  logic [DW+AW-1:0] fifo_rdata_s;
  logic [CW-1:0]  fifo_count_s;
  logic           fifo_empty_s;

  assign resp_s        = imem.imem_valid & outstanding_r;
  assign imem.imem_req  = issue_s;
  assign imem.imem_addr = pc_r;
  assign fifo_wdata_s  = {imem.imem_rdata, req_pc_r + AW'(1)};
  assign pop_s         = !jump_s & !flush_ifid & en_ifid & !fifo_empty_s;

  // Next-state, redirect, issue and push decisions.
  always_comb begin
    state_s = state_r;
    jump_s  = 1'b0;
    issue_s = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt) begin
          state_s = ST_HALTED;
        end else if (jump) begin
          jump_s = 1'b1;
          // The in-flight word belongs to the old stream; wait for it and drop it.
          if (outstanding_r & !imem.imem_valid) begin
            state_s = ST_DISCARD;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          push_s  = resp_s;
          // Counting occupancy with nothing outstanding reserves a slot for the reply.
          issue_s = started_r & en_pc & !outstanding_r & (fifo_count_s < CW'(QDEPTH));
        end
      end
      ST_DISCARD: begin
        if (halt) begin
          state_s = ST_HALTED;
        end else begin
          jump_s = jump;
          if (resp_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DISCARD;
          end
        end
      end
      ST_HALTED: begin
        state_s = ST_HALTED;
      end
      default: begin
        state_s = ST_HALTED;
      end
    endcase
  end

  // PC, request tracking and FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      req_pc_r      <= RESET_PC;
      outstanding_r <= 1'b0;
      started_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      started_r <= 1'b1;
      if (jump_s) begin
        pc_r <= jump_target;
      end else if (issue_s) begin
        pc_r <= pc_r + AW'(1);
      end else begin
        pc_r <= pc_r;
      end
      if (issue_s) begin
        req_pc_r <= pc_r;
      end
      if (issue_s) begin
        outstanding_r <= 1'b1;
      end else if (resp_s) begin
        outstanding_r <= 1'b0;
      end else begin
        outstanding_r <= outstanding_r;
      end
    end
  end

  fetch_fifo #(
    .W     (DW + AW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (jump_s),
    .push  (push_s),
    .wdata (fifo_wdata_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // IF/ID register; a bubble keeps the previous pcinc_id.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_id  <= DW'(INST_NOP);
      pcinc_id <= {AW{1'b0}};
      flushed  <= 1'b1;
    end else if (jump_s | flush_ifid) begin
      inst_id <= DW'(INST_NOP);
      flushed <= 1'b1;
    end else if (!en_ifid) begin
      inst_id  <= inst_id;
      pcinc_id <= pcinc_id;
      flushed  <= flushed;
    end else if (!fifo_empty_s) begin
      inst_id  <= fifo_rdata_s[DW+AW-1:AW];
      pcinc_id <= fifo_rdata_s[AW-1:0];
      flushed  <= 1'b0;
    end else begin
      inst_id <= DW'(INST_NOP);
      flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction-memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pcinc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [15:0] jump_target;
  logic        en_pc;
  logic        en_ifid;
  logic        flush_ifid;
  logic        halt;
  logic [15:0] inst_id;
  logic [15:0] pcinc_id;
  logic        flushed;

  int   n_checks = 0;
  int   n_errors = 0;
  int   lat = 1;
  logic pend;
  int   cnt;
  logic [15:0] paddr;
  logic en_q;
  ent_t sq[$];
  int   mark;
  int   n_req;

  fetch_unit_if #(.AW(16), .DW(16)) bus ();

  fetch_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .jump        (jump),
    .jump_target (jump_target),
    .en_pc       (en_pc),
    .en_ifid     (en_ifid),
    .flush_ifid  (flush_ifid),
    .halt        (halt),
    .imem        (bus),
    .inst_id     (inst_id),
    .pcinc_id    (pcinc_id),
    .flushed     (flushed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd4) return 16'h1111 * (a + 16'd1);
    else return a ^ 16'h5A00;
  endfunction

  // Memory: reply exactly lat cycles after the request cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      cnt <= 0;
      paddr <= 16'h0000;
      bus.imem_valid <= 1'b0;
      bus.imem_rdata <= 16'h0000;
    end else begin
      bus.imem_valid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem_word(paddr);
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req) begin
        if (lat == 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem_word(bus.imem_addr);
        end else begin
          pend <= 1'b1;
          cnt <= lat - 1;
          paddr <= bus.imem_addr;
        end
      end
    end
  end

  // Record every instruction freshly loaded into IF/ID.
  always @(posedge clk) begin
    en_q = en_ifid;
    #1;
    if (reset && en_q && !flushed) sq.push_back('{inst: inst_id, pcinc: pcinc_id});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ent(input string tag, input int idx, input logic [15:0] ei, input logic [15:0] ep);
    if (idx < sq.size()) begin
      check_val({tag, "_inst"}, {16'h0000, sq[idx].inst}, {16'h0000, ei});
      check_val({tag, "_pcinc"}, {16'h0000, sq[idx].pcinc}, {16'h0000, ep});
    end else begin
      check_val({tag, "_missing"}, sq.size(), idx + 1);
    end
  endtask

  task automatic wait_req(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.imem_req) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val({tag, "_req_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; jump = 1'b0; jump_target = 16'h0000; en_pc = 1'b0;
    en_ifid = 1'b1; flush_ifid = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_inst", {16'h0, inst_id}, {16'h0, INST_NOP});
    check_val("rst_pcinc", {16'h0, pcinc_id}, 32'h0);
    check_val("rst_flushed", {31'd0, flushed}, 32'd1);
    check_val("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_val("rst_addr", {16'h0, bus.imem_addr}, 32'h0);

    // 1: latency-1 streaming
    en_pc = 1'b1;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_val("t1_count", {31'd0, sq.size() >= 4}, 32'd1);

    // 2: decode stall fills the FIFO and stops requests
    en_ifid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_val("t2_fifo_full", 32'(u_dut.u_fifo.count_r), 32'd2);
    check_val("t2_req_idle", {31'd0, bus.imem_req}, 32'd0);
    check_val("t2_hold_inst", {16'h0, inst_id}, 32'h5A04);
    check_val("t2_hold_pcinc", {16'h0, pcinc_id}, 32'h0005);
    en_ifid = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 8; k++) check_ent($sformatf("t12_seq%0d", k), k, mem_word(16'(k)), 16'(k + 1));

    // 3: jump with a latency-3 request outstanding
    lat = 3;
    wait_req("t3");
    @(negedge clk);
    jump = 1'b1; jump_target = 16'h0040; mark = sq.size();
    @(negedge clk);
    jump = 1'b0;
    check_val("t3_state", 32'(u_dut.state_r), 32'(ST_DISCARD));
    check_val("t3_fifo_clr", 32'(u_dut.u_fifo.count_r), 32'd0);
    repeat (12) @(negedge clk);
    check_ent("t3_first", mark, 16'h5A40, 16'h0041);

    // 4: jump in the same cycle as the response
    lat = 1;
    wait_req("t4");
    @(negedge clk);
    check_val("t4_valid", {31'd0, bus.imem_valid}, 32'd1);
    jump = 1'b1; jump_target = 16'h0040; mark = sq.size();
    @(negedge clk);
    jump = 1'b0;
    #1;
    check_val("t4_state", 32'(u_dut.state_r), 32'(ST_RUN));
    check_val("t4_outst", {31'd0, u_dut.outstanding_r}, 32'd0);
    check_val("t4_req", {31'd0, bus.imem_req}, 32'd1);
    check_val("t4_addr", {16'h0, bus.imem_addr}, 32'h0040);
    repeat (6) @(negedge clk);
    check_ent("t4_first", mark, 16'h5A40, 16'h0041);

    // 5: PC wrap at 16'hFFFF
    jump = 1'b1; jump_target = 16'hFFFF; mark = sq.size();
    @(negedge clk);
    jump = 1'b0;
    wait_req("t5a");
    check_val("t5_addr_ffff", {16'h0, bus.imem_addr}, 32'hFFFF);
    @(negedge clk);
    wait_req("t5b");
    check_val("t5_addr_wrap", {16'h0, bus.imem_addr}, 32'h0000);
    repeat (6) @(negedge clk);
    check_ent("t5_top", mark, 16'hA5FF, 16'h0000);
    check_ent("t5_next", mark + 1, 16'h1111, 16'h0001);

    // 6a: halt mid-stream
    lat = 2;
    repeat (3) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_val("t6_state", 32'(u_dut.state_r), 32'(ST_HALTED));
    n_req = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.imem_req) n_req++;
    end
    check_val("t6_no_req", n_req, 32'd0);
    check_val("t6_outst", {31'd0, u_dut.outstanding_r}, 32'd0);

    // 6b: asynchronous reset while a request is outstanding
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; lat = 3;
    repeat (15) @(negedge clk);
    wait_req("t6b");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("t6b_inst", {16'h0, inst_id}, {16'h0, INST_NOP});
    check_val("t6b_pcinc", {16'h0, pcinc_id}, 32'h0);
    check_val("t6b_flushed", {31'd0, flushed}, 32'd1);
    check_val("t6b_req", {31'd0, bus.imem_req}, 32'd0);
    check_val("t6b_addr", {16'h0, bus.imem_addr}, 32'h0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
